// File: rtl/eth_stat_pkg.sv
// rtl/eth_stat_pkg.sv - shared constants for the Ethernet statistics block
// Purpose: event bit indices within a MAC status vector and the register
// offsets used by the per-port register window.
// Ports: none (package).
package eth_stat_pkg;

  // Event bit positions in each port's 16-bit status vector
  localparam int EV_TX_OVF       = 0;
  localparam int EV_TX_BAD       = 1;
  localparam int EV_TX_GOOD      = 2;
  localparam int EV_TX_UNDERFLOW = 3;
  localparam int EV_RX_BAD       = 4;
  localparam int EV_RX_FCS       = 5;
  localparam int EV_RX_OVF       = 6;
  localparam int EV_RX_FIFO_BAD  = 7;
  localparam int EV_RX_GOOD      = 8;
  localparam int NUM_EVENTS      = 9;

  // Register offsets within a port window (offsets 0..8 are the counters)
  localparam logic [3:0] OFF_MASK   = 4'd14;
  localparam logic [3:0] OFF_STICKY = 4'd15;

endpackage

// File: rtl/eth_stat_port.sv
// rtl/eth_stat_port.sv - per-port saturating counters, sticky flags and mask
// Purpose: one MAC port's statistics state.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   ev_i             event pulses (status bits 8:0)
//   wr_i             register write targeting this port
//   clr_rd_i         clear-on-read request (read targeting this port)
//   off_i            register offset
//   wdata_i          write data bits 8:0
//   cnt_o            all counters, event e at [e*CNT_WIDTH +: CNT_WIDTH]
//   sticky_o, mask_o sticky flags and interrupt mask
//   irq_o            local interrupt term OR(sticky & mask)
module eth_stat_port
  import eth_stat_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_EVENTS-1:0]           ev_i,
  input  logic                            wr_i,
  input  logic                            clr_rd_i,
  input  logic [3:0]                      off_i,
  input  logic [NUM_EVENTS-1:0]           wdata_i,
  output logic [NUM_EVENTS*CNT_WIDTH-1:0] cnt_o,
  output logic [NUM_EVENTS-1:0]           sticky_o,
  output logic [NUM_EVENTS-1:0]           mask_o,
  output logic                            irq_o
);

  logic [CNT_WIDTH-1:0]  cnt_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] sticky_q, sticky_d;
  logic [NUM_EVENTS-1:0] mask_q, mask_d;

  always_comb begin
    for (int e = 0; e < NUM_EVENTS; e++) begin
      cnt_d[e] = cnt_q[e];
      // A clear racing an event leaves the count at 1, not 0
      if ((wr_i || clr_rd_i) && off_i == 4'(e))
        cnt_d[e] = ev_i[e] ? CNT_WIDTH'(1) : '0;
      else if (ev_i[e] && cnt_q[e] != '1)
        cnt_d[e] = cnt_q[e] + CNT_WIDTH'(1);
    end
  end

  // Set wins over W1C because the event OR is applied last
  assign sticky_d = (sticky_q & ~((wr_i && off_i == OFF_STICKY) ? wdata_i : '0)) | ev_i;
  assign mask_d   = (wr_i && off_i == OFF_MASK) ? wdata_i : mask_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int e = 0; e < NUM_EVENTS; e++) cnt_q[e] <= '0;
      sticky_q <= '0;
      mask_q   <= '0;
    end else begin
      for (int e = 0; e < NUM_EVENTS; e++) cnt_q[e] <= cnt_d[e];
      sticky_q <= sticky_d;
      mask_q   <= mask_d;
    end
  end

  for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_cnt_out
    assign cnt_o[e*CNT_WIDTH +: CNT_WIDTH] = cnt_q[e];
  end

  assign sticky_o = sticky_q;
  assign mask_o   = mask_q;
  assign irq_o    = |(sticky_q & mask_q);

endmodule

// File: rtl/eth_stat_counters.sv
// rtl/eth_stat_counters.sv - Ethernet MAC statistics counters with register bus
// Purpose: per-port event counters, sticky flags and maskable interrupt.
// Ports:
//   clock125, reset   clock, synchronous active-high reset
//   status_vector     16 bits per port; bits 8:0 are event pulses
//   reg_addr          {port, offset[3:0]}
//   reg_rd, reg_wr    one-cycle read/write strobes
//   reg_wdata         write data
//   reg_rdata         read data, held until the next read
//   reg_rvalid        read data valid, one cycle after reg_rd
//   irq               level interrupt
module eth_stat_counters
  import eth_stat_pkg::*;
#(
  parameter int NUM_PORTS     = 1,
  parameter int CNT_WIDTH     = 32,
  parameter int CLEAR_ON_READ = 0,
  parameter int ADDR_WIDTH    = $clog2(NUM_PORTS) + 4
) (
  input  logic                    clock125,
  input  logic                    reset,
  input  logic [16*NUM_PORTS-1:0] status_vector,
  input  logic [ADDR_WIDTH-1:0]   reg_addr,
  input  logic                    reg_rd,
  input  logic                    reg_wr,
  input  logic [31:0]             reg_wdata,
  output logic [31:0]             reg_rdata,
  output logic                    reg_rvalid,
  output logic                    irq
);

  logic [NUM_EVENTS*CNT_WIDTH-1:0] cnt_flat [NUM_PORTS];
  logic [NUM_EVENTS-1:0]           sticky   [NUM_PORTS];
  logic [NUM_EVENTS-1:0]           mask     [NUM_PORTS];
  logic [NUM_PORTS-1:0]            irq_term;
  logic [31:0]                     port_num;
  logic [3:0]                      offset;
  logic [31:0]                     rd_val;
  logic [31:0]                     rdata_q;
  logic                            rvalid_q;
  logic                            irq_q;
  logic                            unused_wdata;

  assign offset       = reg_addr[3:0];
  assign unused_wdata = ^reg_wdata[31:NUM_EVENTS];

  // A single-port build has no port field; everything maps to port 0
  if (ADDR_WIDTH > 4) begin : g_pidx
    assign port_num = 32'(reg_addr[ADDR_WIDTH-1:4]);
  end else begin : g_pidx0
    assign port_num = '0;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic unused_hi;
    assign unused_hi = ^status_vector[16*p+NUM_EVENTS +: 16-NUM_EVENTS];

    eth_stat_port #(.CNT_WIDTH(CNT_WIDTH)) u_port (
      .clk_i    (clock125),
      .reset_i  (reset),
      .ev_i     (status_vector[16*p +: NUM_EVENTS]),
      .wr_i     (reg_wr && port_num == 32'(p)),
      .clr_rd_i ((CLEAR_ON_READ != 0) && reg_rd && port_num == 32'(p)),
      .off_i    (offset),
      .wdata_i  (reg_wdata[NUM_EVENTS-1:0]),
      .cnt_o    (cnt_flat[p]),
      .sticky_o (sticky[p]),
      .mask_o   (mask[p]),
      .irq_o    (irq_term[p])
    );
  end

  // Ports beyond NUM_PORTS and offsets 9..13 never match and read 0
  always_comb begin
    rd_val = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_num == 32'(p)) begin
        for (int e = 0; e < NUM_EVENTS; e++)
          if (offset == 4'(e)) rd_val = 32'(cnt_flat[p][e*CNT_WIDTH +: CNT_WIDTH]);
        if (offset == OFF_MASK)   rd_val = 32'(mask[p]);
        if (offset == OFF_STICKY) rd_val = 32'(sticky[p]);
      end
    end
  end

  always_ff @(posedge clock125) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= reg_rd;
      if (reg_rd) rdata_q <= rd_val;
      irq_q <= |irq_term;
    end
  end

  assign reg_rdata = rdata_q;
  // A read in flight when reset arrives is dropped
  assign reg_rvalid = rvalid_q & ~reset;
  assign irq        = irq_q;

endmodule

// File: tb/tb_eth_stat_counters.sv
// tb/tb_eth_stat_counters.sv - directed scoreboard bench for eth_stat_counters
module tb_eth_stat_counters;

  localparam int NP = 3;
  localparam int CW = 8;
  localparam int AW = 6;

  logic          clock125 = 1'b0;
  logic          reset = 1'b1;
  logic [16*NP-1:0] status_vector = '0;
  logic [AW-1:0] reg_addr = '0;
  logic          reg_rd = 1'b0;
  logic          reg_wr = 1'b0;
  logic [31:0]   reg_wdata = '0;
  logic [31:0]   reg_rdata;
  logic          reg_rvalid;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  eth_stat_counters #(.NUM_PORTS(NP), .CNT_WIDTH(CW), .CLEAR_ON_READ(1)) dut (
    .clock125      (clock125),
    .reset         (reset),
    .status_vector (status_vector),
    .reg_addr      (reg_addr),
    .reg_rd        (reg_rd),
    .reg_wr        (reg_wr),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .reg_rvalid    (reg_rvalid),
    .irq           (irq)
  );

  always #4 clock125 = ~clock125;

  task automatic tick;
    @(posedge clock125);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr(input int p, input int off);
    return AW'(p * 16 + off);
  endfunction

  task automatic rd(input string tag, input int p, input int off, input logic [31:0] exp);
    reg_addr = addr(p, off);
    reg_rd   = 1'b1;
    exp_q.push_back(exp);
    tick;
    reg_rd = 1'b0;
    check({tag, "_rvalid"}, {31'b0, reg_rvalid}, 32'd1);
    if (exp_q.size() != 0) check(tag, reg_rdata, exp_q.pop_front());
  endtask

  task automatic wr(input int p, input int off, input logic [31:0] data);
    reg_addr  = addr(p, off);
    reg_wdata = data;
    reg_wr    = 1'b1;
    tick;
    reg_wr = 1'b0;
  endtask

  task automatic pulse(input int p, input int b, input int n);
    for (int i = 0; i < n; i++) begin
      status_vector[16*p+b] = 1'b1;
      tick;
      status_vector[16*p+b] = 1'b0;
      tick;
    end
  endtask

  initial begin
    tick;
    tick;
    reset = 1'b0;
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_rvalid", {31'b0, reg_rvalid}, 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    for (int off = 0; off < 16; off++) rd($sformatf("rst_p0_off%0d", off), 0, off, 32'd0);

    // Port-1 bad FCS events are isolated from port 0
    pulse(1, 5, 3);
    rd("p1_sticky", 1, 15, 32'h020);
    rd("p0_fcs", 0, 5, 32'd0);
    rd("p1_fcs", 1, 5, 32'd3);
    rd("p1_fcs_cor", 1, 5, 32'd0);

    // Saturation at 255
    status_vector[8] = 1'b1;
    for (int i = 0; i < 300; i++) tick;
    status_vector[8] = 1'b0;
    rd("p0_sat", 0, 8, 32'd255);
    rd("p0_sat_cor", 0, 8, 32'd0);

    // Unmapped offsets and out-of-range port
    rd("p0_off10", 0, 10, 32'd0);
    wr(3, 14, 32'h1FF);
    rd("p3_mask", 3, 14, 32'd0);
    check("irq_unmapped", {31'b0, irq}, 32'd0);

    // Interrupt set and W1C timing
    wr(0, 14, 32'h001);
    rd("p0_mask", 0, 14, 32'h001);
    status_vector[0] = 1'b1;
    tick;
    status_vector[0] = 1'b0;
    check("irq_n1", {31'b0, irq}, 32'd0);
    tick;
    check("irq_n2", {31'b0, irq}, 32'd1);
    rd("p0_sticky", 0, 15, 32'h101);
    wr(0, 15, 32'h001);
    check("w1c_n1", {31'b0, irq}, 32'd1);
    tick;
    check("w1c_n2", {31'b0, irq}, 32'd0);

    // W1C racing an event keeps the bit set
    pulse(0, 0, 1);
    check("irq_reset", {31'b0, irq}, 32'd1);
    status_vector[0] = 1'b1;
    reg_addr  = addr(0, 15);
    reg_wdata = 32'h001;
    reg_wr    = 1'b1;
    tick;
    reg_wr = 1'b0;
    status_vector[0] = 1'b0;
    tick;
    check("w1c_race_irq", {31'b0, irq}, 32'd1);
    rd("w1c_race_sticky", 0, 15, 32'h101);
    wr(0, 15, 32'h1FF);
    tick;
    check("irq_cleared", {31'b0, irq}, 32'd0);

    // Clear-on-read
    pulse(0, 2, 4);
    rd("cor_4", 0, 2, 32'd4);
    rd("cor_0", 0, 2, 32'd0);
    pulse(0, 2, 2);
    reg_addr = addr(0, 2);
    reg_rd   = 1'b1;
    status_vector[2] = 1'b1;
    exp_q.push_back(32'd2);
    tick;
    reg_rd = 1'b0;
    status_vector[2] = 1'b0;
    check("cor_race_rvalid", {31'b0, reg_rvalid}, 32'd1);
    check("cor_race_old", reg_rdata, exp_q.pop_front());
    rd("cor_race_left", 0, 2, 32'd1);

    // Write clears a counter; write racing an event leaves 1
    pulse(0, 3, 2);
    wr(0, 3, 32'd0);
    rd("wr_clear", 0, 3, 32'd0);
    pulse(0, 3, 2);
    status_vector[3] = 1'b1;
    wr(0, 3, 32'hDEADBEEF);
    status_vector[3] = 1'b0;
    rd("wr_race", 0, 3, 32'd1);

    // Simultaneous read and write: read sees pre-write value
    wr(1, 14, 32'h0A0);
    reg_addr  = addr(1, 14);
    reg_wdata = 32'h055;
    reg_rd    = 1'b1;
    reg_wr    = 1'b1;
    exp_q.push_back(32'h0A0);
    tick;
    reg_rd = 1'b0;
    reg_wr = 1'b0;
    check("rdwr_old", reg_rdata, exp_q.pop_front());
    rd("rdwr_new", 1, 14, 32'h055);
    tick;
    check("irq_p1_unmasked", {31'b0, irq}, 32'd0);

    // Reset with a read in flight
    pulse(1, 1, 1);
    reg_addr = addr(1, 15);
    reg_rd   = 1'b1;
    tick;
    reg_rd = 1'b0;
    reset  = 1'b1;
    #1;
    check("rst_drop_rvalid", {31'b0, reg_rvalid}, 32'd0);
    tick;
    reset = 1'b0;
    check("rst2_irq", {31'b0, irq}, 32'd0);
    check("rst2_rvalid", {31'b0, reg_rvalid}, 32'd0);
    check("rst2_rdata", reg_rdata, 32'd0);
    rd("rst2_p0_mask", 0, 14, 32'd0);
    rd("rst2_p1_mask", 1, 14, 32'd0);
    rd("rst2_p1_sticky", 1, 15, 32'd0);
    rd("rst2_p0_cnt3", 0, 3, 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_stat_counters.md
# eth_stat_counters

Parametrised statistics and error-capture block for one or more 1G Ethernet MAC ports. It consumes each port's 16-bit MAC status vector, whose bits 0..8 are single-cycle event pulses from the MAC/FIFO wrapper, and keeps per-event saturating counters, sticky event flags and a maskable interrupt. Software reads all of this over a simple register bus. It sits beside the MAC wrappers in the 125 MHz logic domain, between the MAC status outputs and the SoC register/interrupt fabric.

## Interface
Parameters:
- NUM_PORTS, 1: number of MAC ports monitored (1..8).
- CNT_WIDTH, 32: counter width in bits (8..32); read data is zero-extended to 32.
- CLEAR_ON_READ, 0: when 1, reading a counter clears it.
- ADDR_WIDTH, derived: clog2(NUM_PORTS)+4, with a minimum of 4.

Ports:
- clock125  in  1  clock; single clock domain.
- reset  in  1  reset, synchronous active-high.
- status_vector  in  16*NUM_PORTS  port p occupies bits [16p+15:16p]. Bits 0..8 are events: tx_fifo_overflow, tx_fifo_bad_frame, tx_fifo_good_frame, tx_error_underflow, rx_error_bad_frame, rx_error_bad_fcs, rx_fifo_overflow, rx_fifo_bad_frame, rx_fifo_good_frame. Bits 9..15 are ignored.
- reg_addr  in  ADDR_WIDTH  bits [ADDR_WIDTH-1:4] are the port, bits [3:0] are the offset.
- reg_rd  in  1  read strobe, one cycle.
- reg_wr  in  1  write strobe, one cycle.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data.
- reg_rvalid  out  1  read data valid pulse.
- irq  out  1  level interrupt.

## Operation
- Per port, offsets 0..8 are the event counters. Each counter increments by 1 in every cycle its status bit is high.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Offset 14 is the interrupt mask (bits 8:0, R/W).
- Offset 15 holds the sticky flags (bits 8:0). A flag is set by its event; writing 1 to a bit clears it (W1C).
- A write to counter offsets 0..8 clears that counter, regardless of the write data.
- Offsets 9..13, and any port index ≥ NUM_PORTS, read 0; writes to them are ignored.
- irq = OR over all ports of OR(sticky & mask).
- CLEAR_ON_READ=1: a counter read returns the pre-clear value and the counter is cleared in the same cycle.
- Simultaneous events:
  - A clear (write or clear-on-read) and an event on the same counter in the same cycle leave the counter at 1.
  - W1C and a set on the same sticky bit in the same cycle leave the bit set.
  - reg_rd and reg_wr in the same cycle: the write executes, and the read returns the value from before the write.
- Reset mid-operation clears everything in the next cycle. A read in flight is dropped (reg_rvalid=0).

## Timing
- Reset values: all counters 0, sticky 0, mask 0, irq 0, reg_rdata 0, reg_rvalid 0.
- Read latency is 1 cycle: reg_rd at cycle N gives reg_rvalid=1 and reg_rdata valid at N+1. reg_rdata holds its value until the next read.
- An event at cycle N is reflected in a read issued at N+1 or later. A read issued at cycle N sees the value from before the event.
- A write at cycle N takes effect at N+1.
- irq is registered:
  - A sticky bit set at N+1 (event at N) asserts irq at N+2 if the bit is masked in.
  - A W1C at N deasserts irq at N+2.
- No back-pressure: a new read or write is accepted every cycle.

## Structure
- Package eth_stat_pkg holds:
  - event index constants (EV_TX_OVF=0 … EV_RX_GOOD=8) and NUM_EVENTS=9;
  - offsets OFF_MASK=14 and OFF_STICKY=15.
- Sub-module eth_stat_port is instantiated NUM_PORTS times via generate. Per port it contains 9 saturating counters, the sticky and mask registers, and a local irq term.
- The top level does the address decode, a registered read mux and the irq OR-reduction.

## Test plan
- Reset, then read all offsets of port 0 → every read returns 0 and irq=0.
- NUM_PORTS=2: pulse port-1 bit 5 (bad FCS) 3 times → port-1 offset 5 reads 3, port-1 sticky=0x020, port-0 offset 5 reads 0.
- CNT_WIDTH=8: hold port-0 bit 8 high for 300 cycles → offset 8 reads 255.
- Write mask=0x001 to port 0, then pulse bit 0 → irq=1 two cycles after the pulse. Write 0x001 to offset 15 → irq=0 two cycles after the write. Repeat with the W1C and an event in the same cycle → sticky bit stays 1 and irq stays 1.
- CLEAR_ON_READ=1: count 4 events on bit 2, then read offset 2 → returns 4. Read again → returns 0. Repeat with a read and an event in the same cycle → read returns the old value and the counter ends at 1.
- Assert reset in the cycle after reg_rd → reg_rvalid=0, and all state is 0 afterwards.
